// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: register block, TX FIFO and frame FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line high; waits for tx_en with a byte queued, then pops it
//   S_START | start bit, line low for one bit time
//   S_DATA  | eight data bits, LSB first, shifted out of r_shift
//   S_STOP  | stop bit, line high; may pop the next byte and go straight to S_START
module uart_tx_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDR    = 32'hA000_0000,
  parameter int              CLKS_PER_BIT = 868,
  parameter int              FIFO_DEPTH   = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_write_en_i,
  input  logic [XLEN-1:0] mem_write_data_i,
  input  logic            mem_read_en_i,
  output logic [XLEN-1:0] mem_read_data_o,
  output logic            uart_tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_baud, w_baud_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_tx_en, r_ovf;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_rdata;

  logic            w_hit, w_wr_ctrl, w_wr_txdat, w_wr_stat;
  logic            w_full, w_empty, w_push, w_pop, w_go, w_baud_tc;
  logic [3:0]      w_off;
  logic [XLEN-1:0] w_stat;
  logic            w_unused;

  assign w_hit      = (mem_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign w_off      = mem_addr_i[3:0];
  assign w_wr_ctrl  = mem_write_en_i & w_hit & (w_off == 4'h0);
  assign w_wr_txdat = mem_write_en_i & w_hit & (w_off == 4'h4);
  assign w_wr_stat  = mem_write_en_i & w_hit & (w_off == 4'h8);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = w_wr_txdat & ~w_full;
  assign w_go       = r_tx_en & ~w_empty;
  assign w_baud_tc  = (r_baud == '0);
  assign w_unused   = ^mem_write_data_i[XLEN-1:8];

  assign mem_read_data_o = r_rdata;
  assign uart_tx_o       = r_tx;

  // Status word assembled from live FIFO/FSM state.
  always_comb begin
    w_stat         = '0;
    w_stat[0]      = (r_state != S_IDLE);
    w_stat[1]      = w_full;
    w_stat[2]      = w_empty;
    w_stat[3]      = r_ovf;
    w_stat[8 +: CW] = r_count;
  end

  // Control register and sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_en <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_tx_en <= mem_write_data_i[0];
      if (w_wr_txdat && w_full) r_ovf <= 1'b1;
      else if (w_wr_stat && mem_write_data_i[3]) r_ovf <= 1'b0;
    end
  end

  // Registered load data; zero unless a hit on a readable register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rdata <= '0;
    end else if (mem_read_en_i && w_hit) begin
      case (w_off)
        4'h0:    r_rdata <= {{(XLEN-1){1'b0}}, r_tx_en};
        4'h8:    r_rdata <= w_stat;
        default: r_rdata <= '0;
      endcase
    end else begin
      r_rdata <= '0;
    end
  end

  // FIFO storage; contents are don't-care until counted in, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= mem_write_data_i[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM state, baud counter, shifter and registered line output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next-state logic; the baud counter reloads at every bit boundary.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = w_baud_tc ? '0 : r_baud - BW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_tc) begin
          w_baud_nxt    = BAUD_RELOAD;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_tc) begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_STOP: begin
        if (w_baud_tc) begin
          if (w_go) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_baud_nxt  = BAUD_RELOAD;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus random register traffic,
// all compared cycle by cycle against a frame-timeline model of the transmitter.
module tb_uart_tx_ctrl;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hA000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_TXD  = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] mem_addr_i = '0;
  logic        mem_write_en_i = 1'b0;
  logic [31:0] mem_write_data_i = '0;
  logic        mem_read_en_i = 1'b0;
  logic [31:0] mem_read_data_o;
  logic        uart_tx_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  uart_tx_ctrl #(
    .XLEN(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .mem_addr_i(mem_addr_i),
    .mem_write_en_i(mem_write_en_i), .mem_write_data_i(mem_write_data_i),
    .mem_read_en_i(mem_read_en_i), .mem_read_data_o(mem_read_data_o),
    .uart_tx_o(uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: queue of pending bytes plus a countdown of cycles left in the frame on the wire.
  logic [7:0]  m_q[$];
  bit          m_tx_en, m_ovf;
  int          m_rem;
  logic [7:0]  m_byte;
  logic [31:0] m_rd;

  function automatic logic m_line();
    int pos;
    if (m_rem == 0) return 1'b1;
    pos = (FRAME - m_rem) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_byte[pos-1];
  endfunction

  task automatic model_step();
    bit full_pre, hit, pop;
    logic [3:0]  off;
    logic [31:0] rd;
    full_pre = (m_q.size() == DEPTH);
    hit = (mem_addr_i[31:4] == BASE[31:4]);
    off = mem_addr_i[3:0];
    rd = '0;
    if (mem_read_en_i && hit) begin
      if (off == 4'h0) rd = {31'b0, m_tx_en};
      else if (off == 4'h8)
        rd = (32'(m_q.size()) << 8) | (32'(m_ovf) << 3) | (32'(m_q.size() == 0) << 2)
           | (32'(full_pre) << 1) | 32'(m_rem > 0);
    end
    pop = (m_rem <= 1) && m_tx_en && (m_q.size() > 0);
    if (pop) begin
      m_byte = m_q.pop_front();
      m_rem  = FRAME;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (mem_write_en_i && hit) begin
      if (off == 4'h0) m_tx_en = mem_write_data_i[0];
      if (off == 4'h4) begin
        if (!full_pre) m_q.push_back(mem_write_data_i[7:0]);
        else m_ovf = 1'b1;
      end
      if (off == 4'h8 && mem_write_data_i[3]) m_ovf = 1'b0;
    end
    m_rd = rd;
  endtask

  initial begin
    m_tx_en = 0; m_ovf = 0; m_rem = 0; m_byte = '0; m_rd = '0;
    forever begin
      @(posedge clk_i or posedge reset_i);
      if (reset_i) begin
        m_q.delete();
        m_tx_en = 0; m_ovf = 0; m_rem = 0; m_byte = '0; m_rd = '0;
      end else begin
        model_step();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of line and read data against the model.
  initial forever begin
    @(negedge clk_i);
    if (chk_en && !reset_i) begin
      chk("model_line", {31'b0, uart_tx_o}, {31'b0, m_line()});
      chk("model_rdata", mem_read_data_o, m_rd);
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_addr_i = addr; mem_write_data_i = data; mem_write_en_i = 1'b1;
    @(negedge clk_i);
    mem_write_en_i = 1'b0;
  endtask

  task automatic rd_val(input logic [31:0] addr, output logic [31:0] v);
    mem_addr_i = addr; mem_read_en_i = 1'b1;
    @(negedge clk_i);
    mem_read_en_i = 1'b0;
    v = mem_read_data_o;
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] v;
    rd_val(addr, v);
    chk(name, v, exp);
  endtask

  // Called on the negedge right after the pop edge; samples mid-bit of contiguous frames.
  logic [7:0] exp_bytes[$];
  task automatic sample_frames();
    logic [7:0] b;
    logic       e;
    repeat (2) @(negedge clk_i);
    for (int f = 0; f < exp_bytes.size(); f++) begin
      b = exp_bytes[f];
      for (int k = 0; k < 10; k++) begin
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        chk($sformatf("frame%0d_bit%0d", f, k), {31'b0, uart_tx_o}, {31'b0, e});
        repeat (CPB) @(negedge clk_i);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int unsigned r;
    bit done;
    string s;

    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    chk_en  = 1'b1;

    // Reset state
    chk("reset_line", {31'b0, uart_tx_o}, 32'h1);
    rd_chk(A_STAT, 32'h0000_0004, "reset_stat");
    rd_chk(A_CTRL, 32'h0, "reset_ctrl");

    // Single frame 0x48
    wr(A_TXD, 32'h48);
    wr(A_CTRL, 32'h1);
    @(negedge clk_i);
    exp_bytes = '{8'h48};
    sample_frames();
    rd_chk(A_STAT, 32'h0000_0004, "single_stat");

    // Twelve back-to-back frames
    wr(A_CTRL, 32'h0);
    s = "Hello World!";
    exp_bytes.delete();
    for (int i = 0; i < s.len(); i++) begin
      exp_bytes.push_back(s[i]);
      wr(A_TXD, {24'b0, s[i]});
    end
    rd_chk(A_STAT, 32'h0000_0C00, "hello_queued");
    wr(A_CTRL, 32'h1);
    @(negedge clk_i);
    sample_frames();
    rd_chk(A_STAT, 32'h0000_0004, "hello_done_stat");

    // Overflow with 17 pushes while disabled
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) wr(A_TXD, $urandom);
    rd_chk(A_STAT, 32'h0000_100A, "ovf_stat");
    wr(A_STAT, 32'h8);
    rd_chk(A_STAT, 32'h0000_1002, "ovf_cleared");
    wr(A_CTRL, 32'h1);
    done = 1'b0;
    v = '0;
    for (int i = 0; i < 1000 && !done; i++) begin
      rd_val(A_STAT, v);
      if (v == 32'h4) done = 1'b1;
    end
    chk("drain_stat", v, 32'h4);

    // Disable mid-frame
    wr(A_CTRL, 32'h0);
    wr(A_TXD, 32'($urandom_range(0, 255)));
    wr(A_TXD, 32'h00);
    wr(A_CTRL, 32'h1);
    repeat (8) @(negedge clk_i);
    wr(A_CTRL, 32'h0);
    repeat (50) @(negedge clk_i);
    chk("disabled_line", {31'b0, uart_tx_o}, 32'h1);
    rd_chk(A_STAT, 32'h0000_0100, "disabled_stat");

    // Reset mid-DATA of the all-zero byte
    wr(A_CTRL, 32'h1);
    repeat (10) @(negedge clk_i);
    chk("pre_reset_line", {31'b0, uart_tx_o}, 32'h0);
    reset_i = 1'b1;
    #1;
    chk("reset_async_line", {31'b0, uart_tx_o}, 32'h1);
    @(negedge clk_i);
    reset_i = 1'b0;
    rd_chk(A_STAT, 32'h0000_0004, "post_reset_stat");
    rd_chk(A_CTRL, 32'h0, "post_reset_ctrl");

    // Random traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 7) wr(A_TXD, $urandom);
      else if (r < 9) wr(A_CTRL, ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0));
      else if (r < 10) wr(A_STAT, $urandom);
      else if (r < 11) wr(BASE + 32'hC, $urandom);
      else if (r < 12) wr(32'hB000_0004, $urandom);
      else if (r < 25) begin
        case ($urandom_range(0, 4))
          0: rd_val(A_CTRL, v);
          1: rd_val(A_TXD, v);
          2: rd_val(A_STAT, v);
          3: rd_val(BASE + 32'hC, v);
          default: rd_val(32'hB000_0008, v);
        endcase
      end else @(negedge clk_i);
    end
    repeat (5) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
